// File: rtl/sram_port0_ctrl_pkg.sv
// Shared constants, FSM state type and request record for the port-0 SRAM controller.
package sram_ctrl_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int RSP_DEPTH  = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } sram_req_t;

    // Buffer occupancy after this edge, counting the read whose data is still on dout0.
    function automatic logic rsp_has_room(input logic [1:0] count,
                                          input logic       pop,
                                          input logic       pending);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
        return (occ < 3'(RSP_DEPTH));
    endfunction

endpackage

// File: rtl/sram_port0_ctrl_if.sv
// Request/response handshake bundle between core logic (master) and the SRAM controller (slave).
interface sram_port0_ctrl_if;
    import sram_ctrl_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_port0_ctrl_rsp_fifo2.sv
// Two-entry synchronous response FIFO; simultaneous push and pop keep the count unchanged.
module sram_rsp_fifo2
    import sram_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_r [2];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Qualify push/pop against occupancy so the pointers can never run past each other.
    always_comb begin
        do_pop_s  = pop & (count_r != 2'd0);
        do_push_s = push & ((count_r != 2'd2) | do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_r[0] <= {DATA_WIDTH{1'b0}};
            mem_r[1] <= {DATA_WIDTH{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/sram_port0_ctrl.sv
// Port-0 controller for the sky130 OpenRAM 32x512 macro: request channel -> macro pins, dout0 -> response FIFO.
// Optional SRAM_CTRL_INIT_EN: zero-fill all 512 words after reset before accepting requests.
module sram_port0_ctrl
    import sram_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port0_ctrl_if.slave      bus,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

`ifdef SRAM_CTRL_INIT_EN
    localparam ctrl_state_t           RESET_STATE = INIT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    logic [ADDR_WIDTH-1:0] init_addr_r;
`else
    localparam ctrl_state_t RESET_STATE = RUN;
`endif

    ctrl_state_t           state_r;
    ctrl_state_t           state_next;
    logic                  rd_pending_r;
    sram_req_t             req_s;
    logic                  req_ready_s;
    logic                  rd_accept_s;
    logic                  rd_room_s;
    logic                  init_done_s;
    logic                  rsp_valid_s;
    logic                  pop_s;
    logic [1:0]            fifo_count_s;
    logic [DATA_WIDTH-1:0] fifo_head_s;
    logic                  csb_s;
    logic                  web_s;
    logic [NUM_WMASKS-1:0] wmask_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] din_s;

    assign req_s = '{we: bus.req_we, wmask: bus.req_wmask, addr: bus.req_addr, wdata: bus.req_wdata};

    assign rsp_valid_s = rst_n & (fifo_count_s != 2'd0);
    assign pop_s       = rsp_valid_s & bus.rsp_ready;
    assign rd_room_s   = rsp_has_room(fifo_count_s, pop_s, rd_pending_r);
    assign rd_accept_s = bus.req_valid & req_ready_s & ~req_s.we;

    // Next state, handshake and macro pin drive; pins idle unless a cycle is really issued.
    always_comb begin
        state_next  = state_r;
        req_ready_s = 1'b0;
        init_done_s = 1'b0;
        csb_s       = 1'b1;
        web_s       = 1'b1;
        wmask_s     = {NUM_WMASKS{1'b0}};
        addr_s      = {ADDR_WIDTH{1'b0}};
        din_s       = {DATA_WIDTH{1'b0}};
        if (rst_n) begin
            case (state_r)
                RUN: begin
                    init_done_s = 1'b1;
                    req_ready_s = req_s.we | rd_room_s;
                    if (bus.req_valid && req_ready_s) begin
                        csb_s   = 1'b0;
                        web_s   = ~req_s.we;
                        wmask_s = req_s.wmask;
                        addr_s  = req_s.addr;
                        din_s   = req_s.wdata;
                    end else begin
                        csb_s   = 1'b1;
                    end
                end
                INIT: begin
`ifdef SRAM_CTRL_INIT_EN
                    csb_s   = 1'b0;
                    web_s   = 1'b0;
                    wmask_s = {NUM_WMASKS{1'b1}};
                    addr_s  = init_addr_r;
                    din_s   = {DATA_WIDTH{1'b0}};
                    if (init_addr_r == LAST_ADDR) begin
                        state_next = RUN;
                    end else begin
                        state_next = INIT;
                    end
`else
                    state_next = RUN;
`endif
                end
                default: state_next = RESET_STATE;
            endcase
        end else begin
            state_next = RESET_STATE;
        end
    end

    // FSM state and the one-deep read-in-flight flag (dout0 is valid the cycle after accept).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= RESET_STATE;
            rd_pending_r <= 1'b0;
        end else begin
            state_r      <= state_next;
            rd_pending_r <= rd_accept_s;
        end
    end

`ifdef SRAM_CTRL_INIT_EN
    // Zero-fill address walker; restarts from 0 on every reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (state_r == INIT) begin
            init_addr_r <= init_addr_r + ADDR_ONE;
        end else begin
            init_addr_r <= init_addr_r;
        end
    end
`endif

    sram_rsp_fifo2 u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending_r),
        .push_data (sram_dout0),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .count     (fifo_count_s)
    );

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_rdata = rst_n ? fifo_head_s : {DATA_WIDTH{1'b0}};
    assign init_done     = init_done_s;
    assign sram_csb0     = csb_s;
    assign sram_web0     = web_s;
    assign sram_wmask0   = wmask_s;
    assign sram_addr0    = addr_s;
    assign sram_din0     = din_s;

endmodule
